// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator
//   Collects signed 2N-bit products from a sequential Booth multiplier and
//   accumulates NUM_TERMS of them into a saturating ACC_W-bit dot product.
//   The finished sum is offered on a valid/ready port.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   prod_hi    in   [N-1:0] product upper half
//   prod_lo    in   [N-1:0] product lower half
//   prod_done  in   level; its rising edge marks a new product
//   clear      in   synchronous flush of the current result and error flags
//   acc_out    out  [ACC_W-1:0] signed result; reads 0 unless acc_valid
//   acc_valid  out  result available
//   acc_ready  in   consumer accepts the result
//   term_cnt   out  [CNT_W-1:0] products summed into the current result
//   overflow   out  sticky saturation flag for the current result
//   drop_err   out  sticky flag: a product arrived with the buffer full
//   busy       out  FSM not idle or a product is waiting in the buffer
module booth_mac_accumulator #(
  parameter int N         = 16,
  parameter int ACC_W     = 40,
  parameter int NUM_TERMS = 8,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       prod_hi,
  input  logic [N-1:0]       prod_lo,
  input  logic               prod_done,
  input  logic               clear,
  output logic [ACC_W-1:0]   acc_out,
  output logic               acc_valid,
  input  logic               acc_ready,
  output logic [CNT_W-1:0]   term_cnt,
  output logic               overflow,
  output logic               drop_err,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_TERMS);

  logic [1:0]       state_q, state_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   prod_q, prod_d;
  logic [2*N-1:0]   pend_q, pend_d;
  logic             pending_q, pending_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic             overflow_q, overflow_d;
  logic             drop_err_q, drop_err_d;

  logic             new_prod;
  logic [2*N-1:0]   prod_in;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_wide;
  logic             sat;
  logic [ACC_W-1:0] sum_sat;

  assign new_prod = prod_done & ~done_q;
  assign prod_in  = {prod_hi, prod_lo};
  assign prod_ext = {{(ACC_W-2*N){prod_q[2*N-1]}}, prod_q};

  // One extra bit of headroom: if the two top bits disagree the true sum
  // does not fit in ACC_W bits, and the top bit gives the true sign.
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign sat      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign sum_sat  = !sat ? sum_wide[ACC_W-1:0] :
                    (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX);

  always_comb begin
    state_d    = state_q;
    done_d     = prod_done;
    prod_d     = prod_q;
    pend_d     = pend_q;
    pending_d  = pending_q;
    acc_d      = acc_q;
    term_cnt_d = term_cnt_q;
    overflow_d = overflow_q;
    drop_err_d = drop_err_q;

    if (clear) begin
      // A rising edge coinciding with clear is ignored; done_d still tracks.
      state_d    = S_IDLE;
      pending_d  = 1'b0;
      acc_d      = '0;
      term_cnt_d = '0;
      overflow_d = 1'b0;
      drop_err_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            // Buffered product goes first; a simultaneous arrival refills the buffer.
            prod_d  = pend_q;
            state_d = S_ADD;
            if (new_prod) begin
              pend_d = prod_in;
            end else begin
              pending_d = 1'b0;
            end
          end else if (new_prod) begin
            prod_d  = prod_in;
            state_d = S_ADD;
          end
        end
        S_ADD: begin
          acc_d      = sum_sat;
          overflow_d = overflow_q | sat;
          term_cnt_d = term_cnt_q + CNT_ONE;
          state_d    = S_CHECK;
        end
        S_CHECK: begin
          state_d = (term_cnt_q == CNT_END) ? S_OUT : S_IDLE;
        end
        default: begin
          if (acc_ready) begin
            acc_d      = '0;
            term_cnt_d = '0;
            overflow_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      endcase

      // Outside S_IDLE there is room for exactly one waiting product.
      if (state_q != S_IDLE && new_prod) begin
        if (!pending_q) begin
          pend_d    = prod_in;
          pending_d = 1'b1;
        end else begin
          drop_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      prod_q     <= '0;
      pend_q     <= '0;
      pending_q  <= 1'b0;
      acc_q      <= '0;
      term_cnt_q <= '0;
      overflow_q <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      prod_q     <= prod_d;
      pend_q     <= pend_d;
      pending_q  <= pending_d;
      acc_q      <= acc_d;
      term_cnt_q <= term_cnt_d;
      overflow_q <= overflow_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Valid comes straight from registered state, so ready never loops into it.
  assign acc_valid = (state_q == S_OUT);
  assign acc_out   = acc_valid ? acc_q : '0;
  assign term_cnt  = term_cnt_q;
  assign overflow  = overflow_q;
  assign drop_err  = drop_err_q;
  assign busy      = (state_q != S_IDLE) | pending_q;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Bench for booth_mac_accumulator. Three instances share the inputs:
//   A: default parameters, B: ACC_W=33 (saturation), C: NUM_TERMS=1.
module tb_booth_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] prod_hi, prod_lo;
  logic        prod_done, clear, acc_ready;

  logic [39:0] acc_out_a, acc_out_c;
  logic [32:0] acc_out_b;
  logic        valid_a, valid_b, valid_c;
  logic [3:0]  cnt_a, cnt_b, cnt_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        drop_a, drop_b, drop_c;
  logic        busy_a, busy_b, busy_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mac_accumulator dut_a (
    .clk(clk), .rst(rst), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .prod_done(prod_done), .clear(clear), .acc_out(acc_out_a),
    .acc_valid(valid_a), .acc_ready(acc_ready), .term_cnt(cnt_a),
    .overflow(ovf_a), .drop_err(drop_a), .busy(busy_a)
  );

  booth_mac_accumulator #(.ACC_W(33)) dut_b (
    .clk(clk), .rst(rst), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .prod_done(prod_done), .clear(clear), .acc_out(acc_out_b),
    .acc_valid(valid_b), .acc_ready(acc_ready), .term_cnt(cnt_b),
    .overflow(ovf_b), .drop_err(drop_b), .busy(busy_b)
  );

  booth_mac_accumulator #(.NUM_TERMS(1)) dut_c (
    .clk(clk), .rst(rst), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .prod_done(prod_done), .clear(clear), .acc_out(acc_out_c),
    .acc_valid(valid_c), .acc_ready(acc_ready), .term_cnt(cnt_c),
    .overflow(ovf_c), .drop_err(drop_c), .busy(busy_c)
  );

  // Selected-instance view
  int     cur_sel = 0;
  longint s_acc;
  logic   s_valid, s_busy, s_ovf;
  logic [3:0] s_cnt;

  always_comb begin
    s_acc   = {{24{acc_out_a[39]}}, acc_out_a};
    s_valid = valid_a;
    s_busy  = busy_a;
    s_ovf   = ovf_a;
    s_cnt   = cnt_a;
    if (cur_sel == 1) begin
      s_acc   = {{31{acc_out_b[32]}}, acc_out_b};
      s_valid = valid_b;
      s_busy  = busy_b;
      s_ovf   = ovf_b;
      s_cnt   = cnt_b;
    end else if (cur_sel == 2) begin
      s_acc   = {{24{acc_out_c[39]}}, acc_out_c};
      s_valid = valid_c;
      s_busy  = busy_c;
      s_ovf   = ovf_c;
      s_cnt   = cnt_c;
    end
  end

  typedef struct {
    int     sel;
    int     a;
    int     b;
    int     exp_cnt;
    bit     last;
    longint exp_acc;
    bit     exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic set_prod(input int a, input int b);
    logic signed [31:0] p;
    p = 32'(a * b);
    prod_hi = p[31:16];
    prod_lo = p[15:0];
  endtask

  // Raise prod_done for two cycles, then drop it.
  task automatic send_prod(input int a, input int b);
    @(negedge clk);
    set_prod(a, b);
    prod_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    prod_done = 1'b0;
  endtask

  // kind 0: wait for busy low; kind 1: wait for valid high
  task automatic wait_for(input int kind, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if ((kind == 0 && !s_busy) || (kind == 1 && s_valid)) hit = 1;
      else @(negedge clk);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting (kind %0d) expected event within 30 cycles", name, kind);
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk({name, " valid_after_accept"}, longint'(s_valid), 0);
    chk({name, " cnt_after_accept"}, longint'(s_cnt), 0);
    chk({name, " ovf_after_accept"}, longint'(s_ovf), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    prod_done = 1'b0;
    clear     = 1'b0;
    acc_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit     stable;
    longint held;

    rst = 1'b0; prod_hi = '0; prod_lo = '0;
    prod_done = 1'b0; clear = 1'b0; acc_ready = 1'b0;

    // Vector table
    for (int i = 0; i < 8; i++)
      vecs.push_back('{0, 3, 5, i + 1, i == 7, 120, 1'b0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{0, (i % 2 == 0) ? -7 : 4, (i % 2 == 0) ? 9 : 4, i + 1, i == 7, -188, 1'b0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1, -32768, -32768, i + 1, i == 7, 64'd4294967295, 1'b1});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1, 1, 1, i + 1, i == 7, 8, 1'b0});

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset acc_out", longint'(acc_out_a), 0);
    chk("reset valid", longint'(valid_a), 0);
    chk("reset flags", longint'({cnt_a, ovf_a, drop_a, busy_a}), 0);
    rst = 1'b1;

    // Table-driven: tests 1..3
    foreach (vecs[k]) begin
      cur_sel = vecs[k].sel;
      send_prod(vecs[k].a, vecs[k].b);
      if (!vecs[k].last) begin
        wait_for(0, $sformatf("vec%0d idle", k));
        chk($sformatf("vec%0d term_cnt", k), longint'(s_cnt), vecs[k].exp_cnt);
      end else begin
        wait_for(1, $sformatf("vec%0d valid", k));
        chk($sformatf("vec%0d acc_out", k), s_acc, vecs[k].exp_acc);
        chk($sformatf("vec%0d overflow", k), longint'(s_ovf), longint'(vecs[k].exp_ovf));
        chk($sformatf("vec%0d term_cnt", k), longint'(s_cnt), vecs[k].exp_cnt);
        handshake($sformatf("vec%0d", k));
      end
    end

    // Test 4: backpressure, one buffered product, one dropped
    do_reset();
    cur_sel = 0;
    for (int i = 0; i < 8; i++) begin
      send_prod(1, 1);
      if (i < 7) wait_for(0, "t4 fill");
    end
    wait_for(1, "t4 valid");
    held = s_acc;
    chk("t4 first acc_out", held, 8);
    stable = 1;
    send_prod(2, 3);
    if (!s_valid || s_acc != held) stable = 0;
    send_prod(5, 5);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (!s_valid || s_acc != held) stable = 0;
    end
    chk("t4 held stable", longint'(stable), 1);
    chk("t4 drop_err", longint'(drop_a), 1);
    chk("t4 busy", longint'(busy_a), 1);
    handshake("t4");
    wait_for(0, "t4 pending drain");
    chk("t4 pending term_cnt", longint'(s_cnt), 1);
    chk("t4 drop_err sticky", longint'(drop_a), 1);
    for (int i = 0; i < 7; i++) begin
      send_prod(1, 1);
      if (i < 6) wait_for(0, "t4 refill");
    end
    wait_for(1, "t4 valid2");
    chk("t4 second acc_out", s_acc, 13);
    handshake("t4b");
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("t4 drop_err cleared", longint'(drop_a), 0);

    // Test 5: held level counts once
    do_reset();
    @(negedge clk);
    set_prod(1, 1);
    prod_done = 1'b1;
    repeat (50) @(negedge clk);
    chk("t5 cnt while held", longint'(cnt_a), 1);
    chk("t5 busy while held", longint'(busy_a), 0);
    prod_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5 cnt after release", longint'(cnt_a), 1);

    // Test 6: clear at term 5, clear with coincident edge, reset mid S_ADD
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_prod(1, 1);
      wait_for(0, "t6 fill");
    end
    chk("t6 cnt before clear", longint'(cnt_a), 5);
    @(negedge clk);
    set_prod(1, 1);
    clear = 1'b1;
    prod_done = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t6 cnt after clear", longint'(cnt_a), 0);
    repeat (3) @(negedge clk);
    chk("t6 edge under clear ignored", longint'({cnt_a, busy_a}), 0);
    prod_done = 1'b0;
    @(negedge clk);
    prod_done = 1'b1;
    @(negedge clk);
    chk("t6 in add busy", longint'(busy_a), 1);
    rst = 1'b0;
    #1;
    chk("t6 async reset outputs", longint'({valid_a, cnt_a, ovf_a, drop_a, busy_a}), 0);
    chk("t6 async reset acc_out", longint'(acc_out_a), 0);
    prod_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send_prod(3, 5);
    wait_for(0, "t6 restart");
    chk("t6 restart cnt", longint'(cnt_a), 1);

    // NUM_TERMS=1: every product is a result
    do_reset();
    cur_sel = 2;
    send_prod(3, 5);
    wait_for(1, "c valid");
    chk("c acc_out", s_acc, 15);
    chk("c term_cnt", longint'(s_cnt), 1);
    handshake("c");
    send_prod(-2, 8);
    wait_for(1, "c valid2");
    chk("c acc_out2", s_acc, -16);
    handshake("c2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
